gray_counter: RTL

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with a registered Gray-coded copy.
//
// Optional feature (macro GRAY_COUNTER_PEER_SYNC_EN): brings in a Gray pointer
// from an asynchronous source through a two-flop synchroniser, decodes it to
// binary and reports the modular distance between the local and peer counts.
//
// Parameters
//   DATA      counter width in bits (2..32)
//   SATURATE  0 = wrap at range ends, 1 = hold at range ends
//
// Ports
//   clk        in   1     rising-edge clock
//   reset_n    in   1     asynchronous active-low reset
//   clr        in   1     synchronous clear to zero (highest priority)
//   load       in   1     synchronous load of load_val
//   load_val   in   DATA  binary value to load
//   en         in   1     count enable
//   up         in   1     direction, 1 = increment, 0 = decrement
//   bin        out  DATA  registered binary count
//   gray       out  DATA  registered Gray-coded count
//   at_max     out  1     bin is all ones (decoded from the register)
//   at_min     out  1     bin is zero (decoded from the register)
//   wrap       out  1     one-cycle pulse, count crossed a range end
//   peer_gray  in   DATA  async Gray pointer            (macro only)
//   peer_bin   out  DATA  decoded synchronised peer     (macro only)
//   diff       out  DATA  (bin - peer_bin) mod 2^DATA   (macro only)

module gray_counter #(
  parameter int unsigned DATA     = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            load,
  input  logic [DATA-1:0] load_val,
  input  logic            en,
  input  logic            up,
  output logic [DATA-1:0] bin,
  output logic [DATA-1:0] gray,
  output logic            at_max,
  output logic            at_min,
  output logic            wrap
`ifdef GRAY_COUNTER_PEER_SYNC_EN
  ,
  input  logic [DATA-1:0] peer_gray,
  output logic [DATA-1:0] peer_bin,
  output logic [DATA-1:0] diff
`endif
);

  localparam int unsigned W = DATA;
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ZERO     = {W{1'b0}};
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] bin_q;
  logic [W-1:0] gray_q;
  logic         wrap_q;

  logic [W-1:0] bin_nxt;
  logic [W-1:0] gray_nxt;
  logic         wrap_nxt;

  // Next-count selection: clr over load over en; otherwise hold.
  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (clr) begin
      bin_nxt = ZERO;
    end else if (load) begin
      bin_nxt = load_val;
    end else if (en) begin
      if (up) begin
        if (bin_q == ALL_ONES) begin
          // Range end: saturating build holds, wrapping build rolls to zero.
          if (!SATURATE) begin
            bin_nxt  = ZERO;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_q + ONE;
        end
      end else begin
        if (bin_q == ZERO) begin
          if (!SATURATE) begin
            bin_nxt  = ALL_ONES;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_q - ONE;
        end
      end
    end
  end

  // Gray code of the next value, so the gray register tracks bin with no lag.
  always_comb begin
    gray_nxt = bin_nxt ^ (bin_nxt >> 1);
  end

  // Count, Gray and wrap registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q  <= ZERO;
      gray_q <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bin    = bin_q;
  assign gray   = gray_q;
  assign wrap   = wrap_q;
  assign at_max = (bin_q == ALL_ONES);
  assign at_min = (bin_q == ZERO);

`ifdef GRAY_COUNTER_PEER_SYNC_EN
  logic [W-1:0] peer_s1_q;
  logic [W-1:0] peer_s2_q;
  logic [W-1:0] peer_dec;

  // Two-flop synchroniser; only one bit of a Gray pointer moves per step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peer_s1_q <= ZERO;
      peer_s2_q <= ZERO;
    end else begin
      peer_s1_q <= peer_gray;
      peer_s2_q <= peer_s1_q;
    end
  end

  // Gray to binary: MSB passes through, each lower bit XORs with the bit above.
  always_comb begin
    peer_dec      = ZERO;
    peer_dec[W-1] = peer_s2_q[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      peer_dec[i] = peer_s2_q[i] ^ peer_dec[i+1];
    end
  end

  assign peer_bin = peer_dec;
  assign diff     = W'(bin_q - peer_dec);
`endif

endmodule
